demux41_dist: RTL and testbench
===============================

Name: demux41_dist

Overview:
- Registered 1-to-4 data distributor. It is the receive-side counterpart of the team's 4:1 selector.
- Accepts one WIDTH-bit word per handshake and steers it to one of four output channels.
- The channel is chosen either by explicit select bits {S1,S0} or by an internal round-robin pointer.
- Each channel is a 1-deep holding register with its own valid/ack handshake, so a slow consumer on one channel back-pressures only the words targeted at that channel.

Parameters:
- WIDTH, 8, data width of DIN and each Y output.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- DIN  input  WIDTH  input data word.
- VALID_IN  input  1  DIN valid.
- READY_IN  output  1  block can accept DIN this cycle (combinational).
- MODE  input  1  0 = select by {S1,S0}; 1 = round-robin pointer.
- SYNC  input  1  forces round-robin pointer to channel 0 this cycle.
- S1  input  1  channel select MSB (MODE=0).
- S0  input  1  channel select LSB (MODE=0).
- ACK  input  4  per-channel consumer acknowledge; ACK[i] consumes channel i.
- Y0  output  WIDTH  channel 0 held data.
- Y1  output  WIDTH  channel 1 held data.
- Y2  output  WIDTH  channel 2 held data.
- Y3  output  WIDTH  channel 3 held data.
- V  output  4  per-channel valid; V[i]=1 while Y<i> holds unconsumed data.
- FRAME  output  1  one-cycle pulse: a full round-robin frame completed.

Behaviour:
- Reset (RST_N=0, asynchronous): Y0..Y3=0, V=4'b0000, FRAME=0, pointer PTR=0. READY_IN then follows its combinational equation.
- Effective pointer: EPTR = SYNC ? 0 : PTR.
- Target channel: TGT = MODE ? EPTR : {S1,S0}.
- READY_IN = !V[TGT] | ACK[TGT]. A channel that is full and being acked in the same cycle can be refilled that cycle.
- accept = VALID_IN & READY_IN.
- On accept, at the next edge: Y<TGT> <= DIN; V[TGT] <= 1. Latency is one cycle from accept to Y/V visible.
- ACK[i] with V[i]=1 and no write to channel i: V[i] <= 0. Y<i> keeps its last value; it is not cleared.
- ACK[i] and a write to channel i in the same cycle: V[i] stays 1 and Y<i> takes the new DIN.
- ACK[i] with V[i]=0: ignored, no state change.
- Multiple ACK bits may be asserted together; each channel is handled independently.
- Pointer update:
  - MODE=1 and accept: PTR <= EPTR+1 (2-bit, wraps 3->0).
  - Otherwise: PTR <= EPTR. SYNC therefore clears the pointer even with no transfer.
  - MODE=0: pointer only responds to SYNC and otherwise holds. Switching back to MODE=1 resumes from the held PTR.
- FRAME: registered. FRAME <= MODE & accept & (EPTR==3); otherwise 0. It pulses exactly one cycle after the word for channel 3 is accepted in round-robin mode.
- VALID_IN=1 with READY_IN=0: no state change. The producer holds DIN; this is not an error.
- S1/S0 are don't-care while MODE=1.
- Reset asserted mid-transfer: all held data and valids are discarded immediately and PTR returns to 0. No partial frame survives reset.

Decomposition:
- Shared package holds:
  - constant NCH=4;
  - constant CH_W=2 (channel index width);
  - MODE encodings MODE_SEL=0 and MODE_RR=1.
- One sub-module, demux_chan_reg: a single channel holding register plus valid bit, with inputs wr, din, ack and outputs y, v, full_n (!v | ack). It is instantiated four times.
- Top level contains the target select, the READY_IN mux, the pointer and FRAME logic.

Test Plan:
- Reset: drive RST_N=0 mid-cycle with V=4'b1010 and PTR=2 -> V=0, Y0..Y3=0 and FRAME=0 immediately, with no clock edge required; after release, a MODE=1 write lands in Y0.
- Select mode: MODE=0, {S1,S0}=2, DIN=8'hA5, VALID_IN=1 for one cycle -> next cycle Y2=A5, V=4'b0100; other channels unchanged.
- Back-pressure: channel 1 full with 8'h11, no ACK, VALID_IN=1 with DIN=8'h22 and sel=1 -> READY_IN=0 and Y1 stays 11. Then raise ACK[1] for one cycle -> READY_IN=1 that cycle, Y1=22 next cycle, V[1] stays 1.
- Round robin: MODE=1, stream 8'h01,02,03,04,05 with all ACK=1 -> words land in Y0,Y1,Y2,Y3,Y0; FRAME pulses once, exactly the cycle after 04 is accepted.
- SYNC: MODE=1 with PTR=2, assert SYNC together with VALID_IN and DIN=8'h3C -> Y0=3C, PTR=1 next. SYNC alone with no valid -> PTR=0 and V unchanged.
- Ack on empty plus simultaneous acks: V=4'b0011, ACK=4'b1111 -> V=0000 next cycle, and Y0..Y3 values are retained.

Source files
------------

// File: rtl/demux41_dist_pkg.sv
// Shared constants for the 1-to-4 registered data distributor.
package demux41_dist_pkg;

  // Number of output channels and the width of a channel index.
  localparam int NCH  = 4;
  localparam int CH_W = 2;

  // MODE input encodings.
  localparam logic MODE_SEL = 1'b0;  // channel chosen by {S1,S0}
  localparam logic MODE_RR  = 1'b1;  // channel chosen by round-robin pointer

endpackage

// File: rtl/demux41_dist_chan_reg.sv
// One output channel: a 1-deep holding register with a valid bit and a
// consumer acknowledge. full_n tells the producer side the register can
// take a word this cycle (empty, or being drained right now).
module demux_chan_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             ack,
  output logic [WIDTH-1:0] y,
  output logic             v,
  output logic             full_n
);

  logic [WIDTH-1:0] y_q;
  logic             v_q;

  // Hold register: a write wins over an ack; an ack alone only drops valid,
  // the data stays visible on y.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      v_q <= 1'b0;
    end else if (wr) begin
      y_q <= din;
      v_q <= 1'b1;
    end else if (ack) begin
      v_q <= 1'b0;
    end
  end

  assign y      = y_q;
  assign v      = v_q;
  assign full_n = !v_q || ack;

endmodule

// File: rtl/demux41_dist.sv
// Registered 1-to-4 data distributor. One word per VALID_IN/READY_IN
// handshake is steered to a channel chosen by {S1,S0} or by a round-robin
// pointer; each channel back-pressures only the words aimed at it.
module demux41_dist
  import demux41_dist_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VALID_IN,
  output logic             READY_IN,
  input  logic             MODE,
  input  logic             SYNC,
  input  logic             S1,
  input  logic             S0,
  input  logic [NCH-1:0]   ACK,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [NCH-1:0]   V,
  output logic             FRAME
);

  logic [CH_W-1:0]             ptr_q, ptr_d;
  logic                        frame_q, frame_d;
  logic [CH_W-1:0]             eptr, tgt;
  logic                        accept;
  logic [NCH-1:0]              wr;
  logic [NCH-1:0]              full_n;
  logic [NCH-1:0][WIDTH-1:0]   y_all;

  // Target selection, handshake, per-channel write strobes and next pointer.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    eptr    = SYNC ? '0 : ptr_q;
    tgt     = (MODE == MODE_RR) ? eptr : {S1, S0};
    accept  = VALID_IN && full_n[tgt];
    wr      = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = accept && (tgt == CH_W'(i));
    end
    // SYNC clears the pointer even when nothing is transferred.
    ptr_d   = ((MODE == MODE_RR) && accept) ? eptr + CH_W'(1) : eptr;
    frame_d = (MODE == MODE_RR) && accept && (eptr == CH_W'(NCH - 1));
  end

  assign READY_IN = full_n[tgt];

  // Round-robin pointer and end-of-frame pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      frame_q <= frame_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk    (CLK),
      .rst_n  (RST_N),
      .wr     (wr[g]),
      .din    (DIN),
      .ack    (ACK[g]),
      .y      (y_all[g]),
      .v      (V[g]),
      .full_n (full_n[g])
    );
  end

  assign Y0    = y_all[0];
  assign Y1    = y_all[1];
  assign Y2    = y_all[2];
  assign Y3    = y_all[3];
  assign FRAME = frame_q;

endmodule

// File: tb/tb_demux41_dist.sv
// Self-checking bench for demux41_dist: directed scenarios followed by a
// randomized run, all compared against a behavioural channel/pointer model.
module tb_demux41_dist;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] DIN;
  logic       VALID_IN;
  logic       READY_IN;
  logic       MODE;
  logic       SYNC;
  logic       S1;
  logic       S0;
  logic [3:0] ACK;
  logic [7:0] Y0, Y1, Y2, Y3;
  logic [3:0] V;
  logic       FRAME;

  demux41_dist #(.WIDTH(8)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DIN      (DIN),
    .VALID_IN (VALID_IN),
    .READY_IN (READY_IN),
    .MODE     (MODE),
    .SYNC     (SYNC),
    .S1       (S1),
    .S0       (S0),
    .ACK      (ACK),
    .Y0       (Y0),
    .Y1       (Y1),
    .Y2       (Y2),
    .Y3       (Y3),
    .V        (V),
    .FRAME    (FRAME)
  );

  always #5 CLK = ~CLK;

  // Reference model: four held words, a valid per channel, pointer 0..3.
  logic [7:0] m_y [4];
  logic [3:0] m_v;
  int         m_ptr;
  logic       m_frame;

  int   checks = 0;
  int   passes = 0;
  logic last_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_y[i] = 8'h00;
    m_v     = 4'b0000;
    m_ptr   = 0;
    m_frame = 1'b0;
  endtask

  function automatic int m_target();
    int e;
    e = SYNC ? 0 : m_ptr;
    return MODE ? e : int'({S1, S0});
  endfunction

  function automatic logic [7:0] y_of(input int ch);
    case (ch)
      0:       return Y0;
      1:       return Y1;
      2:       return Y2;
      default: return Y3;
    endcase
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, "_y0"},    Y0,    m_y[0]);
    check({pfx, "_y1"},    Y1,    m_y[1]);
    check({pfx, "_y2"},    Y2,    m_y[2]);
    check({pfx, "_y3"},    Y3,    m_y[3]);
    check({pfx, "_v"},     V,     m_v);
    check({pfx, "_frame"}, FRAME, m_frame);
  endtask

  // One clock of stimulus: drive, check READY_IN, advance model, check outputs.
  // Entered and left 1 time unit after a rising edge.
  task automatic step(input logic vld, input logic [7:0] d, input logic mode,
                      input logic sync, input int sel, input logic [3:0] ack,
                      input string pfx);
    int   t, e;
    logic exp_ready, acc;
    VALID_IN = vld;
    DIN      = d;
    MODE     = mode;
    SYNC     = sync;
    S1       = sel[1];
    S0       = sel[0];
    ACK      = ack;
    #1;
    t         = m_target();
    e         = SYNC ? 0 : m_ptr;
    exp_ready = !m_v[t] || ACK[t];
    check({pfx, "_ready"}, READY_IN, exp_ready);
    last_ready = READY_IN;
    acc = VALID_IN && exp_ready;
    for (int ch = 0; ch < 4; ch++) begin
      if (acc && t == ch) begin
        m_y[ch] = DIN;
        m_v[ch] = 1'b1;
      end else if (ACK[ch]) begin
        m_v[ch] = 1'b0;
      end
    end
    m_frame = MODE && acc && (e == 3);
    m_ptr   = (MODE && acc) ? (e + 1) % 4 : e;
    @(posedge CLK);
    #1;
    check_outputs(pfx);
  endtask

  initial begin
    RST_N = 1'b0; DIN = 8'h00; VALID_IN = 1'b0; MODE = 1'b0; SYNC = 1'b0;
    S1 = 1'b0; S0 = 1'b0; ACK = 4'b0000;
    model_reset();
    #2;
    check_outputs("rst");
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Select mode: word to channel 2 only.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 2, 4'b0000, "sel");
    check("sel_y2_a5", Y2, 8'hA5);
    check("sel_v_0100", V, 4'b0100);

    // Back-pressure on channel 1, then refill in the same cycle as its ack.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1, 4'b0000, "bp_fill");
    step(1'b1, 8'h22, 1'b0, 1'b0, 1, 4'b0000, "bp_stall");
    check("bp_ready_low", last_ready, 1'b0);
    check("bp_y1_hold", Y1, 8'h11);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1, 4'b0010, "bp_ack");
    check("bp_ready_high", last_ready, 1'b1);
    check("bp_y1_new", Y1, 8'h22);
    check("bp_v1_kept", V[1], 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 0, 4'b1111, "drain");
    check("drain_v", V, 4'b0000);

    // Round robin: five words, frame pulse right after the fourth.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(i + 1), 1'b1, 1'b0, 0, 4'b1111, "rr");
      check("rr_land", y_of(i % 4), i + 1);
      check("rr_frame_pulse", FRAME, (i == 3));
    end

    // SYNC with and without a transfer (pointer is at 1, move it to 2).
    step(1'b1, 8'h06, 1'b1, 1'b0, 0, 4'b0000, "pre_sync");
    step(1'b1, 8'h3C, 1'b1, 1'b1, 0, 4'b0001, "sync_wr");
    check("sync_y0_3c", Y0, 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b1, 0, 4'b0000, "sync_idle");
    check("sync_v_same", V, 4'b0011);

    // Simultaneous acks including empty channels: data retained.
    step(1'b0, 8'h00, 1'b1, 1'b0, 0, 4'b1111, "ack_all");
    check("ack_all_v", V, 4'b0000);
    check("ack_all_y0", Y0, 8'h3C);
    check("ack_all_y1", Y1, 8'h06);
    step(1'b1, 8'h77, 1'b1, 1'b0, 0, 4'b0000, "ptr0");
    check("ptr0_y0_77", Y0, 8'h77);

    // Build V=1010 with the pointer at 2, then reset mid-cycle.
    step(1'b1, 8'h88, 1'b1, 1'b0, 0, 4'b0000, "pre_rst_a");
    step(1'b0, 8'h00, 1'b1, 1'b0, 0, 4'b0001, "pre_rst_b");
    step(1'b1, 8'h99, 1'b0, 1'b0, 3, 4'b0000, "pre_rst_c");
    check("pre_rst_v", V, 4'b1010);
    VALID_IN = 1'b0;
    #3;
    RST_N = 1'b0;
    #1;
    model_reset();
    check("arst_v", V, 4'b0000);
    check("arst_y1", Y1, 8'h00);
    check("arst_y3", Y3, 8'h00);
    check("arst_frame", FRAME, 1'b0);
    check_outputs("arst");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step(1'b1, 8'hAB, 1'b1, 1'b0, 2, 4'b0000, "post_rst");
    check("post_rst_y0", Y0, 8'hAB);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      for (int b = 0; b < 4; b++) a[b] = ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3), a, "rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
